cram_burst_ctrl: RTL
====================

Name: cram_burst_ctrl

Overview:
- Parametrised asynchronous-mode controller for the external cellular RAM (PSRAM), successor to the single-word state_machine.
- Adds programmable access/recovery timing, byte enables, multi-word bursts with auto address increment, and a configuration-register (CRE) write mode.
- Sits between the CPU memory stage and the board RAM pins. Handshake: mem strobe in; busy, data_valid, wr_ack, done out.

Parameters:
- DATA_W, 16, RAM data bus width (must be 16; byte lanes lb/ub).
- ADDR_W, 26, word address width.
- BURST_W, 4, burst length field width; words per burst = len+1 (1..16).
- T_ACC_CYC, 4, ACCESS-state cycles (tAA/tWP coverage at system clk); must be >= 1.
- T_REC_CYC, 1, RECOVER cycles with mt_ce_n high between words; must be >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- mem  in  1  request strobe; sampled only in IDLE.
- rw  in  1  0=write, 1=read.
- cfg  in  1  1=configuration-register write (forces write, single word).
- be  in  2  byte enables {ub,lb}, active-high, writes only.
- len  in  BURST_W  burst length minus one.
- addr  in  ADDR_W  start word address.
- data_in  in  DATA_W  write data; current word.
- data_ram  inout  DATA_W  RAM data bus.
- data_out  out  DATA_W  last read word (registered).
- data_valid  out  1  one-cycle pulse, data_out updated.
- wr_ack  out  1  one-cycle pulse, current write word consumed; present next word.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse, burst complete.
- addr_ram  out  ADDR_W-3  RAM address pins (addr[ADDR_W-4:0]).
- clk_ram, adv_z, we_n, oe_n, mt_ce_n, mt_lb_n, mt_ub_n, mt_cre  out  1 each  RAM control pins.

Behaviour:
- Reset (rst=0, async): state IDLE; busy=0, done=0, data_valid=0, wr_ack=0, data_out=0; mt_ce_n=we_n=oe_n=mt_lb_n=mt_ub_n=1; mt_cre=0; clk_ram=0; adv_z=0; data_ram=Z; counters 0. Reset mid-burst aborts immediately; no further pins toggle.
- clk_ram held 0, adv_z held 0 always (asynchronous mode).
- IDLE: busy=0. On a clk edge with mem=1: latch addr, rw, be, len, cfg into registers; go SETUP. mem while busy is ignored. cfg=1 forces rw=0 and len=0.
- SETUP (1 cycle): busy=1, mt_ce_n=0, addr_ram driven; read: lb/ub=0, oe_n=0; write: lb/ub=~be, data_in captured into the drive register on the entry edge, data_ram driven; we_n=1. cfg: mt_cre=1 and lb/ub=0.
- ACCESS (T_ACC_CYC cycles, down-counter): read oe_n=0; write we_n=0. mt_cre held.
- LATCH (1 cycle): read: data_out<=data_ram at the exit edge, data_valid=1 in the following cycle (RECOVER's first cycle). Write: we_n=1, data still driven (hold), wr_ack=1 this cycle. mt_cre=1 until end of LATCH.
- RECOVER (T_REC_CYC cycles): mt_ce_n=1, oe_n=1, we_n=1, lb/ub=1, mt_cre=0, data_ram=Z. Then, if words remain: address+1 (mod 2^ADDR_W), remaining-1, go SETUP; else go IDLE.
- done pulses in the first IDLE cycle after the final RECOVER; busy=0 in that cycle, and mem is accepted there.
- data_ram is driven only in SETUP/ACCESS/LATCH of writes; no read cycle drives it.
- Single-word latency (T_ACC=4, T_REC=1, mem seen at edge 0): SETUP cyc1, ACCESS 2-5, LATCH 6, RECOVER 7 (data_valid for reads), IDLE+done cyc8. Total burst length = (len+1)*(2+T_ACC+T_REC)+1 cycles.
- Address wrap: 2^ADDR_W-1 increments to 0 without error.
- Write data: the producer updates data_in no later than the cycle after wr_ack; data_in is captured on the edge entering the next SETUP.
- be=00 on a write still runs a full cycle with both lanes masked (mt_lb_n=mt_ub_n=1).

Test Plan:
- Reset then single write: addr=0, data_in=16'h0001, be=11 -> SETUP at cyc1, we_n low cyc2-5, data_ram=0001 cyc1-6, wr_ack cyc6, done cyc8, busy high cyc1-7.
- Single read after write: the RAM model returns 16'h0001 -> oe_n low cyc1-6, data_out=0001 with data_valid cyc7, data_ram never driven by the DUT.
- Burst read len=3 at addr=26'h3FFFFFE -> addresses 3FFFFFE, 3FFFFFF, 0, 1; four data_valid pulses 7 cycles apart; one done; busy drops at done.
- Byte write be=01, data_in=16'hABCD -> mt_lb_n=0, mt_ub_n=1 during SETUP-LATCH; readback upper byte unchanged.
- Config write cfg=1, addr=26'h0008_1D1F, rw=1, len=5 -> treated as a single write: mt_cre=1 SETUP-LATCH, we_n pulse, one wr_ack, done at cyc8.
- rst asserted in ACCESS of burst word 2 -> mt_ce_n/we_n/oe_n=1, data_ram=Z, busy=0 immediately; no done; after release mem=0 keeps IDLE; mem pulse while busy is ignored.

Source files
------------

// File: rtl/cram_burst_if.sv
// CPU-side request/response bundle for the cellular RAM burst controller.
// The controller takes the slave modport. The memory stage takes the master modport.
interface cram_burst_if #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 26,
    parameter int BURST_W = 4
) ();
    logic                mem;
    logic                rw;
    logic                cfg;
    logic [1:0]          be;
    logic [BURST_W-1:0]  len;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   data_in;
    logic [DATA_W-1:0]   data_out;
    logic                data_valid;
    logic                wr_ack;
    logic                busy;
    logic                done;

    modport slave (
        input  mem, rw, cfg, be, len, addr, data_in,
        output data_out, data_valid, wr_ack, busy, done
    );

    modport master (
        output mem, rw, cfg, be, len, addr, data_in,
        input  data_out, data_valid, wr_ack, busy, done
    );
endinterface

// File: rtl/cram_burst_ctrl.sv
// Asynchronous-mode cellular RAM (PSRAM) controller with multi-word bursts.
// Each word goes through SETUP -> ACCESS -> LATCH -> RECOVER. The address
// auto-increments between words. A configuration-register write (cfg) is
// always a single-word write with mt_cre asserted.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for mem; done pulses here after a burst ends
// SETUP   | chip selected, address and lanes valid, write data driven
// ACCESS  | T_ACC_CYC cycles of oe_n (read) or we_n (write) asserted
// LATCH   | read data sampled at exit; write data held, we_n released
// RECOVER | T_REC_CYC cycles deselected, then next word or IDLE
//
// DATA_W must be 16, because the byte lanes are fixed as lb/ub.
// T_ACC_CYC and T_REC_CYC must each be at least 1.
module cram_burst_ctrl #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 26,
    parameter int BURST_W   = 4,
    parameter int T_ACC_CYC = 4,
    parameter int T_REC_CYC = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    cram_burst_if.slave          bus,
    inout  wire  [DATA_W-1:0]    data_ram,
    output logic [ADDR_W-4:0]    addr_ram,
    output logic                 clk_ram,
    output logic                 adv_z,
    output logic                 we_n,
    output logic                 oe_n,
    output logic                 mt_ce_n,
    output logic                 mt_lb_n,
    output logic                 mt_ub_n,
    output logic                 mt_cre
);

    localparam int CNT_MAX = (T_ACC_CYC > T_REC_CYC) ? T_ACC_CYC : T_REC_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_ACCESS  = 3'd2,
        S_LATCH   = 3'd3,
        S_RECOVER = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BURST_W-1:0]   rem_q, rem_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic                 rw_q, rw_d;
    logic                 cfg_q, cfg_d;
    logic [1:0]           be_q, be_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic [DATA_W-1:0]    dout_q, dout_d;
    logic                 valid_q, valid_d;
    logic                 done_q, done_d;
    logic                 drv_en;
    logic                 wr_ack_c;

    // State and datapath registers; reset aborts any burst immediately
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            addr_q  <= '0;
            rw_q    <= 1'b0;
            cfg_q   <= 1'b0;
            be_q    <= 2'b00;
            wdata_q <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            addr_q  <= addr_d;
            rw_q    <= rw_d;
            cfg_q   <= cfg_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    // Next-state: sequence each word and step the address and remaining-word count
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        addr_d  = addr_q;
        rw_d    = rw_q;
        cfg_d   = cfg_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        dout_d  = dout_q;
        valid_d = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.mem) begin
                    addr_d  = bus.addr;
                    cfg_d   = bus.cfg;
                    // A configuration access is always a single-word write.
                    rw_d    = bus.rw & ~bus.cfg;
                    rem_d   = bus.cfg ? '0 : bus.len;
                    be_d    = bus.be;
                    wdata_d = bus.data_in;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                cnt_d   = CNT_W'(T_ACC_CYC - 1);
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = S_LATCH;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_LATCH: begin
                if (rw_q) begin
                    dout_d  = data_ram;
                    valid_d = 1'b1;
                end
                cnt_d   = CNT_W'(T_REC_CYC - 1);
                state_d = S_RECOVER;
            end
            S_RECOVER: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (rem_q != '0) begin
                    // The producer has had at least a cycle since wr_ack to present the next word.
                    addr_d  = addr_q + ADDR_W'(1);
                    rem_d   = rem_q - BURST_W'(1);
                    wdata_d = bus.data_in;
                    state_d = S_SETUP;
                end else begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // RAM pin decode from the registered state; inactive levels outside a word
    always_comb begin
        mt_ce_n  = 1'b1;
        oe_n     = 1'b1;
        we_n     = 1'b1;
        mt_lb_n  = 1'b1;
        mt_ub_n  = 1'b1;
        mt_cre   = 1'b0;
        drv_en   = 1'b0;
        wr_ack_c = 1'b0;

        if (state_q == S_SETUP || state_q == S_ACCESS || state_q == S_LATCH) begin
            mt_ce_n = 1'b0;
            mt_cre  = cfg_q;
            if (rw_q) begin
                oe_n    = 1'b0;
                mt_lb_n = 1'b0;
                mt_ub_n = 1'b0;
            end else begin
                drv_en = 1'b1;
                if (cfg_q) begin
                    mt_lb_n = 1'b0;
                    mt_ub_n = 1'b0;
                end else begin
                    mt_lb_n = ~be_q[0];
                    mt_ub_n = ~be_q[1];
                end
                if (state_q == S_ACCESS) begin
                    we_n = 1'b0;
                end
                if (state_q == S_LATCH) begin
                    wr_ack_c = 1'b1;
                end
            end
        end
    end

    assign data_ram = drv_en ? wdata_q : {DATA_W{1'bz}};
    assign addr_ram = addr_q[ADDR_W-4:0];
    // Asynchronous mode: no RAM clock and no address-valid strobe.
    assign clk_ram  = 1'b0;
    assign adv_z    = 1'b0;

    assign bus.busy       = (state_q != S_IDLE);
    assign bus.done       = done_q;
    assign bus.data_valid = valid_q;
    assign bus.data_out   = dout_q;
    assign bus.wr_ack     = wr_ack_c;

endmodule
